// File: rtl/apb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_pkg
// Purpose  : Shared types, direction codes and range helper for apb_mem_ws.
// Revision : 1.0
// ============================================================================
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  function automatic logic is_oor(input logic [31:0] addr, input logic [31:0] depth);
    return (addr >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_bank.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_bank
// Purpose  : Byte-strobed synchronous RAM with sync clear and registered read.
// Revision : 1.0
// ============================================================================
module apb_mem_bank #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB    = WIDTH / 8
) (
  input  logic             pclk_i,
  input  logic             prst_i,
  input  logic             i_we,
  input  logic             i_re,
  input  logic             i_rzero,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [NB-1:0]    i_wstrb,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        for (int b = 0; b < NB; b++) begin
          if (i_wstrb[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end
      // Out-of-range reads return zero rather than aliasing into the array.
      if (i_re) begin
        r_rdata <= i_rzero ? '0 : r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/apb_mem_ws.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_ws
// Purpose  : APB slave scratch RAM with wait states, byte strobes and error.
// Revision : 1.0
// ============================================================================
module apb_mem_ws
  import apb_mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwr_rd_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [WIDTH-1:0]      pwdata_i,
  input  logic [WIDTH/8-1:0]    pstrb_i,
  output logic [WIDTH-1:0]      prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o
);

  localparam int BANK_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WIDTH % 8 != 0) begin : g_bad_width
    $error("apb_mem_ws: WIDTH must be a multiple of 8");
  end
  if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("apb_mem_ws: DEPTH exceeds address space");
  end
  if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_ws
    $error("apb_mem_ws: WAIT_STATES must be 0..15");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_dir;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH/8-1:0]    r_strb;
  logic                  r_pready;
  logic                  r_pslverr;

  logic w_latch;
  logic w_cnt_dec;
  logic w_do_op;
  logic w_oor;
  logic w_we;
  logic w_re;

  assign w_oor = is_oor(32'(r_addr), 32'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_dec   = 1'b0;
    w_do_op     = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel_i && !penable_i) begin
          w_latch     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          w_state_nxt = IDLE;
        end else if (penable_i) begin
          if (r_cnt != 4'd0) begin
            w_cnt_dec = 1'b1;
          end else begin
            w_do_op     = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_dir     <= DIR_READ;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr  <= paddr_i;
        r_dir   <= pwr_rd_i;
        r_wdata <= pwdata_i;
        r_strb  <= pstrb_i;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Ready/error exist only for the single RESP cycle that follows the op.
      r_pready  <= w_do_op;
      r_pslverr <= w_do_op & w_oor;
    end
  end

  assign w_we = w_do_op && (r_dir == DIR_WRITE) && !w_oor;
  assign w_re = w_do_op && (r_dir == DIR_READ);

  apb_mem_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_bank (
    .pclk_i  (pclk_i),
    .prst_i  (prst_i),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_rzero (w_oor),
    .i_addr  (r_addr[BANK_AW-1:0]),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .o_rdata (prdata_o)
  );

  assign pready_o  = r_pready;
  assign pslverr_o = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_mem_ws
// Purpose  : Scoreboard bench for apb_mem_ws at WAIT_STATES 0 and 3.
// Revision : 1.0
// ============================================================================
module tb_apb_mem_ws;

  logic        clk = 1'b0;
  logic        prst;
  logic        psel;
  logic        penable;
  logic        pwr;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          cur;

  logic        psel0, psel3;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;
  logic        pslverr0, pslverr3;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][64];
  logic [31:0] last_rd [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign psel0 = psel && (cur == 0);
  assign psel3 = psel && (cur == 1);

  apb_mem_ws #(.WIDTH(32), .DEPTH(64), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
    .pclk_i(clk), .prst_i(prst), .psel_i(psel0), .penable_i(penable), .pwr_rd_i(pwr),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0)
  );

  apb_mem_ws #(.WIDTH(32), .DEPTH(64), .ADDR_WIDTH(8), .WAIT_STATES(3)) u_dut3 (
    .pclk_i(clk), .prst_i(prst), .psel_i(psel3), .penable_i(penable), .pwr_rd_i(pwr),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata3), .pready_o(pready3), .pslverr_o(pslverr3)
  );

  function automatic logic [31:0] rdata();
    return (cur == 1) ? prdata3 : prdata0;
  endfunction
  function automatic logic rdy();
    return (cur == 1) ? pready3 : pready0;
  endfunction
  function automatic logic err();
    return (cur == 1) ? pslverr3 : pslverr0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_models();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) model[d][i] = '0;
      last_rd[d] = '0;
    end
  endtask

  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    exp_t g;
    int   lat;
    int   ws;
    ws     = (cur == 1) ? 3 : 0;
    e.rd   = !wr;
    e.err  = (a >= 8'd64);
    e.data = '0;
    if (!wr && !e.err) e.data = model[cur][a[5:0]];
    if (wr && !e.err) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[cur][a[5:0]][8*b +: 8] = d[8*b +: 8];
    end
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwr = wr; paddr = a; pwdata = d; pstrb = s;
    step();
    // Scramble bus after setup: the DUT must use its latched copy.
    penable = 1'b1; paddr = ~a; pwdata = ~d; pstrb = ~s;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!rdy() && lat < 40);
    chk("ready_latency", lat, ws + 1);
    if (rdy()) begin
      chk("sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
        g = sb.pop_front();
        chk("pslverr", err(), g.err);
        if (g.rd) begin
          chk("prdata", rdata(), g.data);
          last_rd[cur] = rdata();
        end else begin
          chk("wr_keeps_prdata", rdata(), last_rd[cur]);
        end
      end
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    psel = 1'b0; penable = 1'b0;
    step();
    chk("ready_one_cycle", rdy(), 1'b0);
    chk("err_cleared", err(), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwr = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; cur = 0;
    clr_models();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ready0", pready0, 1'b0);
      chk("rst_ready3", pready3, 1'b0);
      chk("rst_prdata", prdata0, 32'h0);
    end
    prst = 1'b0;

    xfer(1'b0, 8'd5, 32'h0, 4'h0);
    chk("rst_err", err(), 1'b0);

    xfer(1'b1, 8'd3, 32'hDEADBEEF, 4'hF);
    xfer(1'b0, 8'd3, 32'h0, 4'h0);
    chk("rd_deadbeef", last_rd[0], 32'hDEADBEEF);

    xfer(1'b1, 8'd7, 32'h11223344, 4'hF);
    xfer(1'b1, 8'd7, 32'hAABBCCDD, 4'b0101);
    xfer(1'b0, 8'd7, 32'h0, 4'h0);
    chk("strobe_merge", last_rd[0], 32'h11BB33DD);
    xfer(1'b1, 8'd7, 32'hFFFFFFFF, 4'h0);
    xfer(1'b0, 8'd7, 32'h0, 4'h0);
    chk("strobe_zero_noop", last_rd[0], 32'h11BB33DD);

    xfer(1'b1, 8'd200, 32'h12345678, 4'hF);
    xfer(1'b0, 8'd200, 32'h0, 4'h0);
    xfer(1'b0, 8'd0, 32'h0, 4'h0);

    cur = 1;
    xfer(1'b1, 8'd9, 32'h12345678, 4'hF);
    xfer(1'b0, 8'd9, 32'h0, 4'h0);
    psel = 1'b1; penable = 1'b0; pwr = 1'b1; paddr = 8'd9; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    step();
    penable = 1'b1;
    step();
    step();
    chk("abort_no_ready", rdy(), 1'b0);
    psel = 1'b0; penable = 1'b0;
    step();
    chk("abort_idle_ready", rdy(), 1'b0);
    xfer(1'b0, 8'd9, 32'h0, 4'h0);
    chk("abort_mem_kept", last_rd[1], 32'h12345678);
    xfer(1'b0, 8'd63, 32'h0, 4'h0);
    xfer(1'b0, 8'd64, 32'h0, 4'h0);

    cur = 0;
    psel = 1'b1; penable = 1'b0; pwr = 1'b1; paddr = 8'd1; pwdata = 32'h55; pstrb = 4'hF;
    step();
    penable = 1'b1; prst = 1'b1;
    step();
    chk("rst_mid_ready", rdy(), 1'b0);
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    clr_models();
    step();
    xfer(1'b0, 8'd1, 32'h0, 4'h0);
    xfer(1'b0, 8'd3, 32'h0, 4'h0);
    xfer(1'b1, 8'd1, 32'h0000A5A5, 4'h3);
    xfer(1'b0, 8'd1, 32'h0, 4'h0);

    for (int i = 0; i < 12; i++) begin
      cur = (i % 3 == 2) ? 1 : 0;
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)), $urandom, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
